extract_field_sched: RTL and testbench
======================================

Name: extract_field_sched

Overview:
- Sequencer that shares LANE_NUM field-extraction lanes across FIELD_NUM per-header-type field slots.
- Sits in each parser stage between the header-window handshake and a bank of single-byte field extractors. The extractor lanes are external; each takes an offset whose top bit is a valid flag and returns the selected unit.
- Holds a programmable per-type offset table and issues one round of LANE_NUM offsets per cycle.
- Collects the results into a field vector and hands it downstream with a valid/ready handshake.

Parameters:
- OFFSET_WIDTH, 7, offset index width; lane offset bus is OFFSET_WIDTH+1 bits, top bit = valid.
- EXTRACT_WIDTH, 8, width of one extracted unit.
- FIELD_NUM, 8, field slots per header type; must be a multiple of LANE_NUM.
- LANE_NUM, 2, extractor lanes driven in parallel.
- TYPE_NUM, 4, number of header types; TYPE_WIDTH = clog2(TYPE_NUM).
- EXT_LAT, 1, extractor output latency in cycles; legal values are 0 (combinational) and 1 (registered).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_hdr_valid  in  1  header window and type are valid; held stable until o_hdr_ready
- i_hdr_type  in  TYPE_WIDTH  header type; selects the table row
- o_hdr_ready  out  1  one-cycle pulse; header consumed
- o_offset  out  LANE_NUM*(OFFSET_WIDTH+1)  per-lane offsets to the extractors
- i_extract_data  in  LANE_NUM*EXTRACT_WIDTH  per-lane extractor results
- o_field_valid  out  1  field vector valid
- i_field_ready  in  1  downstream accepts the vector
- o_field_data  out  FIELD_NUM*EXTRACT_WIDTH  extracted fields; slot f occupies bits [f*EXTRACT_WIDTH +: EXTRACT_WIDTH]
- o_field_mask  out  FIELD_NUM  bit f = slot f's table entry was valid
- i_cfg_wr_en  in  1  table write strobe
- i_cfg_addr  in  TYPE_WIDTH+clog2(FIELD_NUM)  write address = {type, slot}
- i_cfg_wdata  in  OFFSET_WIDTH+1  entry value; top bit = valid
- o_cfg_err  out  1  one-cycle pulse; write rejected
- o_busy  out  1  FSM is not IDLE

Behaviour:
- Reset (asynchronous, active-low) clears:
  - every table entry (all slots invalid) and the FSM (to IDLE);
  - all outputs: o_offset, o_field_data, o_field_mask, o_hdr_ready, o_field_valid, o_cfg_err, o_busy.
- Rounds: R = FIELD_NUM/LANE_NUM. In round r, lane l is driven with table[type][r*LANE_NUM+l].
- FSM states:
  - IDLE: o_offset = 0. When i_hdr_valid=1, latch i_hdr_type, clear the round counter, and go to ISSUE.
  - ISSUE: drive the offsets for round r and increment r. After round R-1, go to DRAIN if EXT_LAT=1, otherwise to OUT.
  - DRAIN (EXT_LAT=1 only): o_offset = 0; capture the final round; go to OUT.
  - OUT: o_field_valid=1 and outputs held stable. On i_field_ready=1, go to IDLE. o_field_valid drops the next cycle.
- Capture timing:
  - EXT_LAT=0: results are captured in the same cycle as their offset.
  - EXT_LAT=1: results are captured one cycle later.
- Capture contents:
  - Slot data = lane result if the entry is valid, else forced 0.
  - Mask bit = entry valid bit.
- o_hdr_ready pulses in the cycle of the final capture.
- Latency from the i_hdr_valid sample in IDLE to o_field_valid: R+1 cycles (EXT_LAT=0) or R+2 cycles (EXT_LAT=1).
- Back-to-back: a new header is not sampled until the FSM has returned to IDLE. Minimum spacing between headers is R+2+EXT_LAT cycles.
- A header type whose row is entirely invalid still runs all R rounds and outputs mask=0, data=0.
- Config writes:
  - Accepted only while o_busy=0; the entry updates on the next edge.
  - A write while o_busy=1 is dropped and o_cfg_err pulses one cycle later.
  - A write in the same cycle IDLE samples i_hdr_valid is dropped (busy is evaluated combinationally as "leaving IDLE").
- i_field_ready while not in OUT: ignored.
- Reset mid-operation: immediate return to IDLE with outputs cleared. No o_hdr_ready is issued for the aborted header.

Optional Feature:
PARSER_EXT_STATS_EN
- Defined: adds two 32-bit outputs, both reset to 0 and both wrapping at 2^32-1 → 0.
  - o_hdr_cnt: increments on each o_hdr_ready.
  - o_stall_cnt: increments on each OUT cycle with i_field_ready=0.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Basic extraction (EXT_LAT=1). Program type 1 slots 0..7 with offsets {0x80|3, 0x80|4, 0, 0x80|10, 0, 0, 0x80|127, 0x80|0}. Send a header with type=1 and unit[k]=k+0x20. Required response:
  - o_field_mask=0xCB;
  - o_field_data slots = {23, 24, 00, 2A, 00, 00, 9F, 20};
  - o_field_valid 6 cycles after the valid sample.
- EXT_LAT=0 build, same stimulus -> identical data and mask; o_field_valid 5 cycles after the valid sample; o_hdr_ready pulses in the ISSUE round-3 cycle.
- Hold downstream: i_field_ready=0 for 10 cycles in OUT -> data stable; o_field_valid stays 1; a second i_hdr_valid is not sampled until the cycle after the handshake; o_stall_cnt=10 with stats enabled.
- Config write while busy: write {type 1, slot 0}=0x85 during ISSUE -> o_cfg_err pulses once and the table is unchanged (next header still returns 0x23 in slot 0); the same write in IDLE takes effect.
- Unprogrammed type 3 after reset -> mask=0, data all 0; o_hdr_ready pulses once.
- Assert reset during ISSUE round 2 -> all outputs 0 immediately; table cleared; no o_hdr_ready; the next header after reset completes normally.

Source files
------------

// File: rtl/extract_field_sched.sv
// rtl/extract_field_sched.sv - round-robins LANE_NUM extractor lanes over FIELD_NUM per-type field slots
// Optional counters o_hdr_cnt / o_stall_cnt are built when PARSER_EXT_STATS_EN is defined.
module extract_field_sched #(
  parameter int OFFSET_WIDTH  = 7,
  parameter int EXTRACT_WIDTH = 8,
  parameter int FIELD_NUM     = 8,
  parameter int LANE_NUM      = 2,
  parameter int TYPE_NUM      = 4,
  parameter int EXT_LAT       = 1,
  localparam int TYPE_WIDTH   = $clog2(TYPE_NUM),
  localparam int SLOT_WIDTH   = $clog2(FIELD_NUM)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_hdr_valid,
  input  logic [TYPE_WIDTH-1:0]                 i_hdr_type,
  output logic                                  o_hdr_ready,
  output logic [LANE_NUM*(OFFSET_WIDTH+1)-1:0]  o_offset,
  input  logic [LANE_NUM*EXTRACT_WIDTH-1:0]     i_extract_data,
  output logic                                  o_field_valid,
  input  logic                                  i_field_ready,
  output logic [FIELD_NUM*EXTRACT_WIDTH-1:0]    o_field_data,
  output logic [FIELD_NUM-1:0]                  o_field_mask,
  input  logic                                  i_cfg_wr_en,
  input  logic [TYPE_WIDTH+SLOT_WIDTH-1:0]      i_cfg_addr,
  input  logic [OFFSET_WIDTH:0]                 i_cfg_wdata,
  output logic                                  o_cfg_err,
`ifdef PARSER_EXT_STATS_EN
  output logic [31:0]                           o_hdr_cnt,
  output logic [31:0]                           o_stall_cnt,
`endif
  output logic                                  o_busy
);
  localparam int OW = OFFSET_WIDTH + 1;
  localparam int R  = FIELD_NUM / LANE_NUM;
  localparam int RW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                            state_q, state_d;
  logic [RW-1:0]                     rnd_q, rnd_d;
  logic [TYPE_WIDTH-1:0]             type_q, type_d;
  logic [OW-1:0]                     table_q [TYPE_NUM][FIELD_NUM];
  logic [OW-1:0]                     row [FIELD_NUM];
  logic [OW-1:0]                     issue_entry [LANE_NUM];
  logic [OW-1:0]                     cap_entry [LANE_NUM];
  logic                              cap_valid;
  logic [RW-1:0]                     cap_rnd;
  logic                              busy_int;
  logic                              cfg_err_q;
  logic [FIELD_NUM*EXTRACT_WIDTH-1:0] field_data_q;
  logic [FIELD_NUM-1:0]              field_mask_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    type_d  = type_q;
    case (state_q)
      IDLE: begin
        if (i_hdr_valid) begin
          state_d = ISSUE;
          rnd_d   = '0;
          type_d  = i_hdr_type;
        end
      end
      ISSUE: begin
        rnd_d = rnd_q + 1'b1;
        if (rnd_q == RW'(R - 1)) state_d = (EXT_LAT == 1) ? DRAIN : OUT;
      end
      DRAIN:   state_d = OUT;
      OUT:     if (i_field_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The row stays valid through DRAIN because table writes are refused while busy.
  always_comb begin
    for (int f = 0; f < FIELD_NUM; f++) row[f] = table_q[type_q][f];
    for (int l = 0; l < LANE_NUM; l++) begin
      issue_entry[l] = '0;
      cap_entry[l]   = '0;
      for (int r = 0; r < R; r++) begin
        if (rnd_q == RW'(r))   issue_entry[l] = row[r*LANE_NUM+l];
        if (cap_rnd == RW'(r)) cap_entry[l]   = row[r*LANE_NUM+l];
      end
    end
  end

  always_comb begin
    o_offset = '0;
    for (int l = 0; l < LANE_NUM; l++)
      o_offset[l*OW +: OW] = (state_q == ISSUE) ? issue_entry[l] : '0;
  end

  generate
    if (EXT_LAT == 0) begin : g_lat0
      assign cap_valid = (state_q == ISSUE);
      assign cap_rnd   = rnd_q;
    end else begin : g_lat1
      logic          pend_q;
      logic [RW-1:0] pend_rnd_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          pend_q     <= 1'b0;
          pend_rnd_q <= '0;
        end else begin
          pend_q     <= (state_q == ISSUE);
          pend_rnd_q <= rnd_q;
        end
      end
      assign cap_valid = pend_q;
      assign cap_rnd   = pend_rnd_q;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      field_data_q <= '0;
      field_mask_q <= '0;
    end else if (cap_valid) begin
      for (int r = 0; r < R; r++) begin
        for (int l = 0; l < LANE_NUM; l++) begin
          if (cap_rnd == RW'(r)) begin
            field_data_q[(r*LANE_NUM+l)*EXTRACT_WIDTH +: EXTRACT_WIDTH] <=
              cap_entry[l][OW-1] ? i_extract_data[l*EXTRACT_WIDTH +: EXTRACT_WIDTH] : '0;
            field_mask_q[r*LANE_NUM+l] <= cap_entry[l][OW-1];
          end
        end
      end
    end
  end

  // A header sampled this cycle already counts as busy, so a coincident write is refused.
  assign busy_int = (state_q != IDLE) || i_hdr_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_err_q <= 1'b0;
      for (int t = 0; t < TYPE_NUM; t++)
        for (int f = 0; f < FIELD_NUM; f++) table_q[t][f] <= '0;
    end else begin
      cfg_err_q <= i_cfg_wr_en && busy_int;
      if (i_cfg_wr_en && !busy_int) begin
        for (int t = 0; t < TYPE_NUM; t++)
          for (int f = 0; f < FIELD_NUM; f++)
            if (i_cfg_addr == {TYPE_WIDTH'(t), SLOT_WIDTH'(f)}) table_q[t][f] <= i_cfg_wdata;
      end
    end
  end

  assign o_hdr_ready   = cap_valid && (cap_rnd == RW'(R - 1));
  assign o_field_valid = (state_q == OUT);
  assign o_busy        = (state_q != IDLE);
  assign o_cfg_err     = cfg_err_q;
  assign o_field_data  = field_data_q;
  assign o_field_mask  = field_mask_q;

`ifdef PARSER_EXT_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hdr_cnt   <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (o_hdr_ready) o_hdr_cnt <= o_hdr_cnt + 32'd1;
      if ((state_q == OUT) && !i_field_ready) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_extract_field_sched.sv
// tb/tb_extract_field_sched.sv - scoreboard bench for extract_field_sched
// Stats ports are connected and checked when PARSER_EXT_STATS_EN is defined.
module tb_extract_field_sched;
  localparam int LAT = 1;
  localparam int R   = 4;
  localparam logic [63:0] D1 = 64'h209F_0000_2A00_2423;
  localparam logic [63:0] D2 = 64'h209F_0000_2A00_2425;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_valid = 1'b0;
  logic [1:0]  hdr_type = 2'd0;
  logic        hdr_ready;
  logic [15:0] offset;
  logic [15:0] ext_data, ext_comb, ext_q;
  logic        field_valid;
  logic        field_ready = 1'b1;
  logic [63:0] field_data;
  logic [7:0]  field_mask;
  logic        cfg_wr_en = 1'b0;
  logic [4:0]  cfg_addr = 5'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        cfg_err;
  logic        busy;
`ifdef PARSER_EXT_STATS_EN
  logic [31:0] hdr_cnt, stall_cnt;
`endif

  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0, n_rdy = 0, n_hdr_exp = 0;
  bit vld_prev = 1'b0;
  logic [7:0] prog [8] = '{8'h83, 8'h84, 8'h00, 8'h8A, 8'h00, 8'h00, 8'hFF, 8'h80};

  extract_field_sched #(.EXT_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_hdr_valid(hdr_valid), .i_hdr_type(hdr_type), .o_hdr_ready(hdr_ready),
    .o_offset(offset), .i_extract_data(ext_data),
    .o_field_valid(field_valid), .i_field_ready(field_ready),
    .o_field_data(field_data), .o_field_mask(field_mask),
    .i_cfg_wr_en(cfg_wr_en), .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata),
    .o_cfg_err(cfg_err),
`ifdef PARSER_EXT_STATS_EN
    .o_hdr_cnt(hdr_cnt), .o_stall_cnt(stall_cnt),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Header window: unit[k] = k + 0x20; invalid lanes return junk the DUT must zero.
  always_comb begin
    ext_comb = 16'h0;
    for (int l = 0; l < 2; l++)
      ext_comb[l*8 +: 8] = offset[l*8+7] ? (8'h20 + {1'b0, offset[l*8 +: 7]}) : 8'hEE;
  end
  always @(posedge clk) ext_q <= ext_comb;
  assign ext_data = (LAT == 1) ? ext_q : ext_comb;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      vld_prev = 1'b0;
    end else begin
      if (!busy && hdr_valid) t0 = cyc;
      if (hdr_ready) begin
        n_rdy++;
        chk("hdr_ready_latency", cyc - t0, R + LAT);
      end
      if (field_valid) begin
        if (!vld_prev) chk("valid_latency", cyc - t0, R + 1 + LAT);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("field_data", field_data, exp_q[0].d);
          chk("field_mask", field_mask, exp_q[0].m);
          if (field_ready) void'(exp_q.pop_front());
        end
      end
      vld_prev = field_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] t, input logic [2:0] s, input logic [7:0] v);
    cfg_wr_en = 1'b1;
    cfg_addr  = {t, s};
    cfg_wdata = v;
    tick();
    cfg_wr_en = 1'b0;
    @(negedge clk);
    chk("cfg_err_idle", cfg_err, 0);
    tick();
  endtask

  task automatic start_header(input logic [1:0] t, input logic [63:0] d, input logic [7:0] m);
    exp_q.push_back('{d, m});
    n_hdr_exp++;
    hdr_valid = 1'b1;
    hdr_type  = t;
  endtask

  task automatic wait_hdr_done();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hdr_ready) break;
    end
    chk("hdr_ready_seen", hdr_ready, 1);
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (field_valid) break;
    end
    chk("field_valid_seen", field_valid, 1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", busy, 0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_offset"}, offset, 0);
    chk({tag, "_data"}, field_data, 0);
    chk({tag, "_mask"}, field_mask, 0);
    chk({tag, "_hdr_ready"}, hdr_ready, 0);
    chk({tag, "_valid"}, field_valid, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef PARSER_EXT_STATS_EN
    chk({tag, "_hdr_cnt"}, hdr_cnt, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 8; s++) cfg_write(2'd1, 3'(s), prog[s]);

    // basic extraction
    start_header(2'd1, D1, 8'hCB);
    wait_hdr_done();
    wait_idle();

    // downstream held for 10 OUT cycles; a queued type-3 header waits for the handshake
    field_ready = 1'b0;
    start_header(2'd1, D1, 8'hCB);
    wait_hdr_done();
    wait_valid();
    tick();
    start_header(2'd3, 64'h0, 8'h00);
    repeat (9) tick();
    field_ready = 1'b1;
    wait_hdr_done();
    wait_idle();
`ifdef PARSER_EXT_STATS_EN
    chk("stall_cnt", stall_cnt, 10);
`endif

    // write during ISSUE is refused and flagged
    start_header(2'd1, D1, 8'hCB);
    tick();
    cfg_wr_en = 1'b1;
    cfg_addr  = {2'd1, 3'd0};
    cfg_wdata = 8'h85;
    tick();
    cfg_wr_en = 1'b0;
    @(negedge clk);
    chk("cfg_err_busy", cfg_err, 1);
    tick();
    @(negedge clk);
    chk("cfg_err_one_pulse", cfg_err, 0);
    wait_hdr_done();
    wait_idle();

    cfg_write(2'd1, 3'd0, 8'h85);
    start_header(2'd1, D2, 8'hCB);
    wait_hdr_done();
    wait_idle();

    // write coinciding with the header sample is dropped
    start_header(2'd1, D2, 8'hCB);
    cfg_wr_en = 1'b1;
    cfg_addr  = {2'd1, 3'd0};
    cfg_wdata = 8'h83;
    tick();
    cfg_wr_en = 1'b0;
    wait_hdr_done();
    wait_idle();

    // reset during ISSUE round 2 aborts the header and clears the table
    start_header(2'd1, D2, 8'hCB);
    repeat (3) tick();
    rst_n     = 1'b0;
    hdr_valid = 1'b0;
    void'(exp_q.pop_back());
    n_hdr_exp--;
    #1;
    check_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();

    start_header(2'd1, 64'h0, 8'h00);
    wait_hdr_done();
    wait_idle();

    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 0);
    chk("hdr_ready_count", n_rdy, n_hdr_exp);
`ifdef PARSER_EXT_STATS_EN
    chk("hdr_cnt_after_reset", hdr_cnt, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
